// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_t       : arbiter FSM states (IDLE, GRANT, TURN)
//   IDLE_*            : bus levels driven whenever no master owns the bus
//   MAX_MASTERS       : largest supported number of requesters
package bus_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam logic IDLE_MODE         = 1'b0;
  localparam logic IDLE_WR_BUS       = 1'b0;
  localparam logic IDLE_MASTER_VALID = 1'b0;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : mask of eligible requests
//   ptr   : index holding the highest priority this round
//   found : high when any bit of req is set
//   idx   : winning index, the first requester at or after ptr (wrapping)
module rr_picker #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic                           found,
  output logic [$clog2(NUM_MASTERS)-1:0] idx
);

  localparam int IW = $clog2(NUM_MASTERS);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // Scan from the farthest offset back towards the pointer so the closest
    // requester is the last assignment and therefore wins. The wrap is an
    // explicit subtraction because NUM_MASTERS need not be a power of two.
    for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the serial system bus between NUM_MASTERS masters.
//   clk, rst                      : clock, synchronous active-high reset
//   m_req                         : per-master request, held for a transaction
//   m_grant                       : one-hot registered grant
//   m_mode/m_wr_bus/m_master_valid: per-master bus drive inputs
//   mode/wr_bus/master_valid      : bus outputs muxed from the owner
//   gnt_id                        : owner index, meaningful while busy
//   busy                          : a grant is active
//   timeout_err                   : one-cycle pulse when a grant is revoked
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         m_req,
  output logic [NUM_MASTERS-1:0]         m_grant,
  input  logic [NUM_MASTERS-1:0]         m_mode,
  input  logic [NUM_MASTERS-1:0]         m_wr_bus,
  input  logic [NUM_MASTERS-1:0]         m_master_valid,
  output logic                           mode,
  output logic                           wr_bus,
  output logic                           master_valid,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_ID  = IW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gnt_id_q, gnt_id_d;
  logic                   busy_q, busy_d;
  logic                   tout_q, tout_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] lock_q, lock_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;

  // A master that timed out stays out of arbitration until it drops m_req.
  assign eligible = m_req & ~lock_q;

  rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req   (eligible),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      tout_q   <= 1'b0;
      ptr_q    <= '0;
      lock_q   <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      tout_q   <= tout_d;
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    tout_d   = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    // Any lockout bit whose request is seen low this cycle is cleared.
    lock_d   = lock_q & m_req;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gnt_id_d          = pick_idx;
          busy_d            = 1'b1;
          cnt_d             = '0;
          ptr_d             = (pick_idx == LAST_ID) ? '0 : pick_idx + IW'(1);
        end
      end
      GRANT: begin
        if (!m_req[gnt_id_q]) begin
          state_d = TURN;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
          state_d          = TURN;
          grant_d          = '0;
          busy_d           = 1'b0;
          tout_d           = 1'b1;
          lock_d[gnt_id_q] = 1'b1;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_grant     = grant_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;

  // The bus follows the registered owner; other masters are never looked at.
  always_comb begin
    mode         = IDLE_MODE;
    wr_bus       = IDLE_WR_BUS;
    master_valid = IDLE_MASTER_VALID;
    if (busy_q) begin
      mode         = m_mode[gnt_id_q];
      wr_bus       = m_wr_bus[gnt_id_q];
      master_valid = m_master_valid[gnt_id_q];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (3 masters, 8-cycle hold timeout).
// A behavioural model predicts the owner after every edge; predictions are
// queued with the cycle they apply to and a monitor compares them on the
// falling edge.
module tb_bus_arbiter;

  localparam int N = 3;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] m_req, m_grant, m_mode, m_wr_bus, m_master_valid;
  logic         mode, wr_bus, master_valid, busy, timeout_err;
  logic [1:0]   gnt_id;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_req          (m_req),
    .m_grant        (m_grant),
    .m_mode         (m_mode),
    .m_wr_bus       (m_wr_bus),
    .m_master_valid (m_master_valid),
    .mode           (mode),
    .wr_bus         (wr_bus),
    .master_valid   (master_valid),
    .gnt_id         (gnt_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner    = -1;  // current owner, -1 when the bus is free
  bit m_turn     = 1'b0;
  int m_ptr      = 0;
  int m_held     = 0;   // grant cycles so far, including the current one
  bit m_lock [N];
  bit m_tout     = 1'b0;
  bit m_after_rst = 1'b0;

  task automatic model_step(input bit r, input logic [N-1:0] q);
    bit nl [N];
    m_tout      = 1'b0;
    m_after_rst = 1'b0;
    if (r) begin
      m_owner = -1; m_turn = 1'b0; m_ptr = 0; m_held = 0; m_after_rst = 1'b1;
      for (int i = 0; i < N; i++) m_lock[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) nl[i] = m_lock[i] && q[i];
      if (m_owner >= 0) begin
        if (!q[m_owner]) begin
          m_owner = -1; m_turn = 1'b1;
        end else if (m_held == T) begin
          nl[m_owner] = 1'b1; m_tout = 1'b1; m_owner = -1; m_turn = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_owner < 0 && q[c] && !m_lock[c]) begin
            m_owner = c; m_held = 1; m_ptr = (c + 1) % N;
          end
        end
      end
      for (int i = 0; i < N; i++) m_lock[i] = nl[i];
    end
  endtask

  typedef struct {
    int tag;
    int owner;
    bit tout;
    bit after_rst;
  } exp_t;

  exp_t sb [$];
  int   seen [$];    // owner index of each new grant seen on the DUT
  int   tout_seen = 0;

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit r, input logic [N-1:0] q);
    exp_t e;
    rst            = r;
    m_req          = q;
    m_mode         = N'($urandom);
    m_wr_bus       = N'($urandom);
    m_master_valid = N'($urandom);
    model_step(r, q);
    e.tag = cyc + 1; e.owner = m_owner; e.tout = m_tout; e.after_rst = m_after_rst;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  bit pol_en [N];
  bit pol_on [N];
  int pol_hold [N];
  int pol_gap [N];
  int pol_left [N];
  int pol_drop_pct = 0;
  bit pol_rand = 1'b0;

  task automatic policy(output logic [N-1:0] q);
    for (int i = 0; i < N; i++) begin
      if (pol_on[i]) begin
        if ((m_owner == i && m_held >= pol_hold[i]) ||
            (m_lock[i] && $urandom_range(99) < pol_drop_pct)) begin
          pol_on[i]   = 1'b0;
          pol_left[i] = pol_gap[i];
          if (pol_rand) begin
            pol_hold[i] = $urandom_range(1, 12);
            pol_gap[i]  = $urandom_range(0, 4);
          end
        end
      end else if (pol_en[i]) begin
        if (pol_left[i] == 0) pol_on[i] = 1'b1;
        else pol_left[i]--;
      end
      q[i] = pol_on[i];
    end
  endtask

  task automatic pol_setup(input int hold, input int gap, input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      pol_en[i] = en[i]; pol_on[i] = en[i];
      pol_hold[i] = hold; pol_gap[i] = gap; pol_left[i] = 0;
    end
  endtask

  function automatic int seen_at(input int k);
    if (k < seen.size()) return seen[k];
    return -1;
  endfunction

  function automatic int seen_count(input int v);
    int n = 0;
    foreach (seen[k]) if (seen[k] == v) n++;
    return n;
  endfunction

  // ---------------- monitor ----------------
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] sel;
    while (sb.size() > 0 && sb[0].tag < cyc) begin
      e = sb.pop_front();
      check("sb_stale_entry", 32'(e.tag), 32'(cyc));
    end
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      e = sb.pop_front();
      sel = (e.owner >= 0) ? (N'(1) << e.owner) : '0;
      check("m_grant", 32'(m_grant), 32'(sel));
      check("busy", 32'(busy), 32'(e.owner >= 0));
      if (e.owner >= 0) check("gnt_id", 32'(gnt_id), 32'(e.owner));
      if (e.after_rst) check("gnt_id_reset", 32'(gnt_id), 32'(0));
      check("timeout_err", 32'(timeout_err), 32'(e.tout));
      check("bus_mode", 32'(mode), 32'(|(m_mode & sel)));
      check("bus_wr_bus", 32'(wr_bus), 32'(|(m_wr_bus & sel)));
      check("bus_master_valid", 32'(master_valid), 32'(|(m_master_valid & sel)));
    end
    if (timeout_err === 1'b1) tout_seen++;
    if (m_grant != '0 && prev_grant == '0) begin
      int idx = -1;
      for (int i = 0; i < N; i++) if (m_grant[i]) idx = i;
      seen.push_back(idx);
    end
    prev_grant = m_grant;
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [N-1:0] q;
    for (int i = 0; i < N; i++) m_lock[i] = 1'b0;

    // Reset and a single requester holding, then releasing.
    repeat (3) tick(1'b1, '0);
    seen.delete();
    repeat (6) tick(1'b0, 3'b001);
    repeat (4) tick(1'b0, 3'b000);
    check("single_grants", 32'(seen.size()), 32'(1));
    check("single_owner", 32'(seen_at(0)), 32'(0));

    // All three requesting, each releasing after 5 grant cycles.
    repeat (2) tick(1'b1, '0);
    seen.delete();
    pol_setup(5, 0, 3'b111);
    pol_drop_pct = 0; pol_rand = 1'b0;
    repeat (26) begin policy(q); tick(1'b0, q); end
    check("rr_order0", 32'(seen_at(0)), 32'(0));
    check("rr_order1", 32'(seen_at(1)), 32'(1));
    check("rr_order2", 32'(seen_at(2)), 32'(2));
    check("rr_order3", 32'(seen_at(3)), 32'(0));

    // Master 0 never releases; master 1 does short transactions.
    repeat (2) tick(1'b1, '0);
    seen.delete(); tout_seen = 0;
    pol_setup(100000, 0, 3'b011);
    pol_hold[1] = 3;
    repeat (30) begin policy(q); tick(1'b0, q); end
    check("to_pulses", 32'(tout_seen), 32'(1));
    check("to_first", 32'(seen_at(0)), 32'(0));
    check("to_second", 32'(seen_at(1)), 32'(1));
    check("to_locked_out", 32'(seen_count(0)), 32'(1));
    policy(q); q[0] = 1'b0; tick(1'b0, q);
    repeat (30) begin policy(q); tick(1'b0, q); end
    check("to_unlocked", 32'(seen_count(0) >= 2), 32'(1));

    // Reset while master 1 owns the bus; master 0 must win afterwards.
    repeat (2) tick(1'b1, '0);
    seen.delete();
    repeat (3) tick(1'b0, 3'b010);
    tick(1'b1, 3'b011);
    repeat (5) tick(1'b0, 3'b011);
    check("rst_first_owner", 32'(seen_at(0)), 32'(1));
    check("rst_next_owner", 32'(seen_at(1)), 32'(0));

    // Random traffic with random hold/gap lengths and occasional reset.
    pol_setup(4, 1, 3'b111);
    pol_drop_pct = 25; pol_rand = 1'b1;
    repeat (2000) begin
      policy(q);
      tick($urandom_range(499) == 0, q);
    end
    repeat (3) tick(1'b0, '0);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
